// File: rtl/serdes_pkg.sv
// serdes_pkg: word-width defaults and data_mod convention shared by serializer and deserializer
package serdes_pkg;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_DATA_MOD_W = $clog2(DEF_DATA_W);
    localparam int MOD_FULL       = 0;
endpackage

// File: rtl/deserializer_if.sv
// deserializer_if: serial input stream and parallel word output of the deserializer
interface deserializer_if import serdes_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DATA_MOD_W = DEF_DATA_MOD_W
);
    logic                  ser_data;
    logic                  ser_data_val;
    logic                  ser_data_last;
    logic [DATA_W-1:0]     deser_data;
    logic [DATA_MOD_W-1:0] deser_data_mod;
    logic                  deser_data_val;
    modport master (
        output ser_data, ser_data_val, ser_data_last,
        input  deser_data, deser_data_mod, deser_data_val
    );
    modport slave (
        input  ser_data, ser_data_val, ser_data_last,
        output deser_data, deser_data_mod, deser_data_val
    );
endinterface

// File: rtl/deserializer_top.sv
// deserializer_top: synthesis wrapper registering all core inputs and outputs for Fmax
module deserializer_top import serdes_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DATA_MOD_W = DEF_DATA_MOD_W
) (
    input logic           clk_i,
    input logic           srst_i,
    deserializer_if.slave bus
);
    deserializer_if #(.DATA_W(DATA_W), .DATA_MOD_W(DATA_MOD_W)) core_bus ();
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            core_bus.ser_data      <= 1'b0;
            core_bus.ser_data_val  <= 1'b0;
            core_bus.ser_data_last <= 1'b0;
            bus.deser_data         <= '0;
            bus.deser_data_mod     <= '0;
            bus.deser_data_val     <= 1'b0;
        end else begin
            core_bus.ser_data      <= bus.ser_data;
            core_bus.ser_data_val  <= bus.ser_data_val;
            core_bus.ser_data_last <= bus.ser_data_last;
            bus.deser_data         <= core_bus.deser_data;
            bus.deser_data_mod     <= core_bus.deser_data_mod;
            bus.deser_data_val     <= core_bus.deser_data_val;
        end
    end
    deserializer #(.DATA_W(DATA_W), .DATA_MOD_W(DATA_MOD_W)) core (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .bus    (core_bus)
    );
endmodule

// File: rtl/deserializer.sv
// deserializer: collects an MSB-first serial stream into left-aligned words, closing early on last
module deserializer import serdes_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DATA_MOD_W = DEF_DATA_MOD_W
) (
    input logic           clk_i,
    input logic           srst_i,
    deserializer_if.slave bus
);
    logic [DATA_W-1:0]     sr;
    logic [DATA_MOD_W-1:0] cnt;
    logic [DATA_W-1:0]     word;
    logic                  full;
    logic                  done;
    always_comb begin
        // sr keeps unfilled low bits at zero, so an early close is already left-aligned
        word = sr | (DATA_W'(bus.ser_data) << (DATA_MOD_W'(DATA_W - 1) - cnt));
        full = cnt == DATA_MOD_W'(DATA_W - 1);
        done = bus.ser_data_last || full;
    end
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sr                 <= '0;
            cnt                <= '0;
            bus.deser_data     <= '0;
            bus.deser_data_mod <= '0;
            bus.deser_data_val <= 1'b0;
        end else begin
            bus.deser_data_val <= bus.ser_data_val && done;
            if (bus.ser_data_val) begin
                sr  <= done ? '0 : word;
                cnt <= done ? '0 : cnt + 1'b1;
                if (done) begin
                    bus.deser_data     <= word;
                    bus.deser_data_mod <= full ? DATA_MOD_W'(MOD_FULL) : cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed checks of the deserializer core with hand-computed expected words
module tb_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses = 0;
    int   cyc = 0;
    deserializer_if bus ();
    deserializer dut (
        .clk_i  (clk),
        .srst_i (rst),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (bus.deser_data_val === 1'b1) pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic l);
        bus.ser_data      = b;
        bus.ser_data_val  = 1'b1;
        bus.ser_data_last = l;
        tick();
        bus.ser_data_val  = 1'b0;
        bus.ser_data_last = 1'b0;
    endtask

    // sends bits w[15] downward; last on the final bit if l; random idle gaps of 1..gmax when gmax>0
    task automatic send_word(input logic [15:0] w, input int n, input logic l, input int gmax);
        for (int i = 0; i < n; i++) begin
            if (gmax > 0) repeat ($urandom_range(1, gmax)) tick();
            send(w[15-i], l && (i == n - 1));
        end
    endtask

    task automatic test_reset();
        bus.ser_data = 1'b0; bus.ser_data_val = 1'b0; bus.ser_data_last = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if (bus.deser_data !== 16'h0) begin n_err++; $display("FAIL reset_data got %h want 0000", bus.deser_data); end
        n_cmp++; if (bus.deser_data_mod !== 4'd0) begin n_err++; $display("FAIL reset_mod got %0d want 0", bus.deser_data_mod); end
        n_cmp++; if (bus.deser_data_val !== 1'b0) begin n_err++; $display("FAIL reset_val got %b want 0", bus.deser_data_val); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full(input int gmax);
        int p0;
        p0 = pulses;
        send_word(16'hA5C3, 15, 1'b0, gmax);
        n_cmp++; if (pulses != p0) begin n_err++; $display("FAIL full_early_pulse gmax=%0d got %0d want 0", gmax, pulses - p0); end
        if (gmax > 0) repeat (3) tick();
        send(1'b1, 1'b0);
        n_cmp++; if (bus.deser_data_val !== 1'b1) begin n_err++; $display("FAIL full_val gmax=%0d got %b want 1", gmax, bus.deser_data_val); end
        n_cmp++; if (bus.deser_data !== 16'hA5C3) begin n_err++; $display("FAIL full_data gmax=%0d got %h want a5c3", gmax, bus.deser_data); end
        n_cmp++; if (bus.deser_data_mod !== 4'd0) begin n_err++; $display("FAIL full_mod gmax=%0d got %0d want 0", gmax, bus.deser_data_mod); end
        tick();
        n_cmp++; if (bus.deser_data_val !== 1'b0) begin n_err++; $display("FAIL full_pulse_width gmax=%0d got %b want 0", gmax, bus.deser_data_val); end
        n_cmp++; if (pulses - p0 != 1) begin n_err++; $display("FAIL full_pulse_count gmax=%0d got %0d want 1", gmax, pulses - p0); end
    endtask

    task automatic test_short();
        int p0;
        p0 = pulses;
        send_word(16'hB000, 5, 1'b1, 0);
        n_cmp++; if (bus.deser_data_val !== 1'b1) begin n_err++; $display("FAIL short5_val got %b want 1", bus.deser_data_val); end
        n_cmp++; if (bus.deser_data !== 16'hB000) begin n_err++; $display("FAIL short5_data got %h want b000", bus.deser_data); end
        n_cmp++; if (bus.deser_data_mod !== 4'd5) begin n_err++; $display("FAIL short5_mod got %0d want 5", bus.deser_data_mod); end
        send(1'b1, 1'b1);
        n_cmp++; if (bus.deser_data_val !== 1'b1) begin n_err++; $display("FAIL short1_val got %b want 1", bus.deser_data_val); end
        n_cmp++; if (bus.deser_data !== 16'h8000) begin n_err++; $display("FAIL short1_data got %h want 8000", bus.deser_data); end
        n_cmp++; if (bus.deser_data_mod !== 4'd1) begin n_err++; $display("FAIL short1_mod got %0d want 1", bus.deser_data_mod); end
        tick();
        n_cmp++; if (pulses - p0 != 2) begin n_err++; $display("FAIL short_pulse_count got %0d want 2", pulses - p0); end
        n_cmp++; if (bus.deser_data !== 16'h8000) begin n_err++; $display("FAIL short_hold got %h want 8000", bus.deser_data); end
    endtask

    task automatic test_back_to_back();
        int c0;
        send_word(16'hFFFF, 16, 1'b0, 0);
        c0 = cyc;
        n_cmp++; if (bus.deser_data_val !== 1'b1 || bus.deser_data !== 16'hFFFF) begin n_err++; $display("FAIL b2b_first got val=%b data=%h want 1/ffff", bus.deser_data_val, bus.deser_data); end
        send_word(16'h0001, 16, 1'b0, 0);
        n_cmp++; if (bus.deser_data_val !== 1'b1 || bus.deser_data !== 16'h0001) begin n_err++; $display("FAIL b2b_second got val=%b data=%h want 1/0001", bus.deser_data_val, bus.deser_data); end
        n_cmp++; if (bus.deser_data_mod !== 4'd0) begin n_err++; $display("FAIL b2b_mod got %0d want 0", bus.deser_data_mod); end
        n_cmp++; if (cyc - c0 != 16) begin n_err++; $display("FAIL b2b_spacing got %0d want 16", cyc - c0); end
        tick();
    endtask

    task automatic test_reset_mid();
        int p0;
        send_word(16'hFE00, 7, 1'b0, 0);
        p0 = pulses;
        rst = 1'b1;
        bus.ser_data = 1'b1; bus.ser_data_val = 1'b1; bus.ser_data_last = 1'b1;
        tick();
        bus.ser_data_val = 1'b0; bus.ser_data_last = 1'b0;
        rst = 1'b0;
        n_cmp++; if (bus.deser_data !== 16'h0 || bus.deser_data_val !== 1'b0 || bus.deser_data_mod !== 4'd0) begin
            n_err++; $display("FAIL midrst_outputs got data=%h mod=%0d val=%b want 0/0/0", bus.deser_data, bus.deser_data_mod, bus.deser_data_val); end
        send_word(16'h1234, 15, 1'b0, 0);
        n_cmp++; if (pulses != p0 || bus.deser_data !== 16'h0) begin n_err++; $display("FAIL midrst_quiet got pulses=%0d data=%h want 0/0000", pulses - p0, bus.deser_data); end
        send(1'b0, 1'b0);
        n_cmp++; if (bus.deser_data_val !== 1'b1 || bus.deser_data !== 16'h1234) begin n_err++; $display("FAIL midrst_word got val=%b data=%h want 1/1234", bus.deser_data_val, bus.deser_data); end
        n_cmp++; if (bus.deser_data_mod !== 4'd0) begin n_err++; $display("FAIL midrst_mod got %0d want 0", bus.deser_data_mod); end
        tick();
    endtask

    task automatic test_last_no_val();
        int p0;
        p0 = pulses;
        bus.ser_data = 1'b1; bus.ser_data_last = 1'b1; bus.ser_data_val = 1'b0;
        repeat (3) tick();
        bus.ser_data_last = 1'b0;
        n_cmp++; if (pulses != p0) begin n_err++; $display("FAIL lastnoval_idle got %0d pulses want 0", pulses - p0); end
        send_word(16'h5A3C, 15, 1'b0, 0);
        n_cmp++; if (pulses != p0) begin n_err++; $display("FAIL lastnoval_early got %0d pulses want 0", pulses - p0); end
        send(1'b0, 1'b1);
        n_cmp++; if (bus.deser_data_val !== 1'b1 || bus.deser_data !== 16'h5A3C) begin n_err++; $display("FAIL lastnoval_word got val=%b data=%h want 1/5a3c", bus.deser_data_val, bus.deser_data); end
        n_cmp++; if (bus.deser_data_mod !== 4'd0) begin n_err++; $display("FAIL lastnoval_mod got %0d want 0", bus.deser_data_mod); end
        tick();
        n_cmp++; if (pulses - p0 != 1) begin n_err++; $display("FAIL lastnoval_count got %0d want 1", pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_full(0);
        test_full(5);
        test_short();
        test_back_to_back();
        test_reset_mid();
        test_last_no_val();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
